// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register with a valid/ready handshake, a one-entry skid buffer,
// synchronous flush and a wrapping count of completed output handshakes.
module pipe_skid_reg #(
    parameter int unsigned          WIDTH     = 64,
    parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{1'b0}},
    parameter int unsigned          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] main_nxt_s;
    logic [WIDTH-1:0] skid_r;
    logic [WIDTH-1:0] skid_nxt_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] cnt_r;
    logic             out_hs_s;

    // Next state and next storage contents; flush overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        main_nxt_s  = main_r;
        skid_nxt_s  = skid_r;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
            main_nxt_s  = RESET_VAL;
            skid_nxt_s  = RESET_VAL;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_valid) begin
                        main_nxt_s  = in_data;
                        state_nxt_s = ST_BUSY;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (in_valid && out_ready) begin
                        main_nxt_s  = in_data;
                        state_nxt_s = ST_BUSY;
                    end else if (in_valid) begin
                        skid_nxt_s  = in_data;
                        state_nxt_s = ST_FULL;
                    end else if (out_ready) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so in_valid cannot be accepted.
                    if (out_ready) begin
                        main_nxt_s  = skid_r;
                        state_nxt_s = ST_BUSY;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                    main_nxt_s  = RESET_VAL;
                    skid_nxt_s  = RESET_VAL;
                end
            endcase
        end
    end

    // State, payload registers and handshake flags, all taken from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            main_r      <= RESET_VAL;
            skid_r      <= RESET_VAL;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            main_r      <= main_nxt_s;
            skid_r      <= skid_nxt_s;
            in_ready_r  <= (state_nxt_s != ST_FULL);
            out_valid_r <= (state_nxt_s != ST_EMPTY);
        end
    end

    // A handshake coinciding with flush is discarded and therefore not counted.
    assign out_hs_s = out_valid_r & out_ready & ~flush;

    // Output transfer counter; wraps naturally and survives flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (out_hs_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;
    assign xfer_cnt  = cnt_r;

endmodule
